wb_arbiter_2m: RTL and testbench
================================

# wb_arbiter_2m

Two-master Wishbone (pipelined, classic-compatible) bus arbiter that shares one slave-side bus between two command masters. An example pair is the UART-driven bus master and a second on-chip requester such as a DMA or self-test engine. Grants are registered and round-robin, and ownership is held for the full `cyc` burst. An optional watchdog aborts cycles that a slave never acknowledges. The block sits between the masters and the address decoder/interconnect.

## Interface
- `AW`, 30, Wishbone word-address width
- `DW`, 32, Wishbone data width
- `TO_W`, 8, watchdog counter width; timeout fires after 2^TO_W−1 cycles
- `i_clk`  in  1  clock
- `i_reset_n`  in  1  reset, asynchronous, active-low
- `i_a_cyc`, `i_a_stb`, `i_a_we`  in  1 each  master A request
- `i_a_addr`  in  AW  master A address
- `i_a_data`  in  DW  master A write data
- `i_a_sel`  in  DW/8  master A byte select
- `o_a_stall`, `o_a_ack`, `o_a_err`  out  1 each  master A responses
- `o_a_data`  out  DW  read data to master A
- `i_b_*` / `o_b_*`: same set as master A, for master B
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`  out  1 each  slave-side bus
- `o_wb_addr`  out  AW  slave-side address
- `o_wb_data`  out  DW  slave-side write data
- `o_wb_sel`  out  DW/8  slave-side byte select
- `i_wb_stall`, `i_wb_ack`, `i_wb_err`  in  1 each  slave responses
- `i_wb_data`  in  DW  slave read data
- `o_owner`  out  2  one-hot current grant {B,A}; 00 = none

## Operation
- States: `IDLE`, `GNT_A`, `GNT_B`, `ABORT` (`ABORT` exists only with the watchdog). Register `last` records the last master served. Reset state is `IDLE`, with `last`=B so that A wins the first tie.
- `IDLE` transitions:
  - A only has `cyc` → `GNT_A`.
  - B only → `GNT_B`.
  - Both → the master that is not `last`.
- `GNT_x` transitions:
  - Stay while `i_x_cyc`=1.
  - When `i_x_cyc`=0: go to `GNT_y` if `i_y_cyc`=1, else `IDLE`.
  - Entering `GNT_x` sets `last`=x.
- Muxing is combinational from the registered state:
  - `o_wb_cyc` = `i_x_cyc` & granted, and `o_wb_stb` = `i_x_stb` & granted.
  - `we`/`addr`/`data`/`sel` come from the owner. They are zero when nothing is granted.
- Owner responses: `o_x_stall`=`i_wb_stall`, `o_x_ack`=`i_wb_ack`, `o_x_err`=`i_wb_err`.
- Non-owner responses: `stall`=1, `ack`=0, `err`=0.
- `o_a_data` = `o_b_data` = `i_wb_data` at all times.
- `i_wb_err` is only passed through. The owner is responsible for dropping `cyc`, and the arbiter does not change state on it.
- Stray `i_wb_ack`/`i_wb_err` while in `IDLE` are ignored; no master sees them.

## Timing
- Reset values (async, immediate):
  - `o_wb_cyc`/`stb`/`we` = 0; `addr`/`data`/`sel` = 0.
  - `o_a_stall` = `o_b_stall` = 1; all `ack`/`err` = 0; `o_owner` = 00.
- Grant latency: `i_x_cyc` rises in cycle N (bus idle) → `o_wb_cyc` = 1 in cycle N+1.
- Handover: owner drops `cyc` in cycle N → bus `cyc` is 0 in N → the other master owns the bus in N+1 (zero dead cycles beyond N).
- The owner may receive `ack` and drop `cyc` in the same cycle; that is legal.
- Reset asserted mid-burst: the bus `cyc` drops asynchronously. In-flight acks are lost, and the masters re-request after reset.

## Configuration
- `WB_ARB_WATCHDOG_EN` defined:
  - A `TO_W`-bit counter clears on grant change, `i_wb_ack`, or `i_wb_err`. It increments while `o_wb_cyc`=1.
  - When the counter reaches all-ones: pulse `o_x_err`=1 to the owner for 1 cycle, force `o_wb_cyc`/`stb` = 0, and enter `ABORT`.
  - `ABORT` keeps both masters stalled and leaves the bus idle. It exits to `IDLE` once the aborted master's `cyc`=0.
- `WB_ARB_WATCHDOG_EN` undefined: no counter and no `ABORT` state. A hung slave holds the grant indefinitely.

## Structure
- Package `wb_pkg`: `AW`/`DW` defaults, `arb_state_t` enum, and the response sub-type constants shared with the bus master and UART decoder.
- Sub-module `wb_arb_watchdog` (counter plus timeout pulse) is instantiated only under the macro. Muxing and the FSM live in the top module.

## Test plan
- After reset release, only A requests with `cyc`/`stb`, `we`=0, `addr`=0x0000010; the slave acks with 0xDEADBEEF after 2 cycles → `o_owner`=01 one cycle after A's `cyc`, `o_a_ack`=1 and `o_a_data`=0xDEADBEEF, B stays stalled.
- A and B both raise `cyc` in the same cycle, three times in a row with single transfers → grants go A, B, A.
- A holds `cyc` for a 4-write burst while B requests → B stays stalled with no ack until A drops `cyc`, then `o_owner`=10 on the next cycle.
- The slave returns `i_wb_err` to B → `o_b_err`=1 that cycle and `o_a_err`=0; the arbiter returns to `IDLE` after B drops `cyc`.
- Watchdog build with `TO_W`=4: the slave never acks A → a single `o_a_err` pulse appears 15 cycles after `cyc`, bus `cyc` goes to 0, and B is granted after A releases.
- Assert `i_reset_n`=0 during B's burst → all outputs take their reset values in the same cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - Shared Wishbone widths, arbiter states and response codes
// WB_ARB_WATCHDOG_EN adds the ABORT state used by the arbiter watchdog.
package wb_pkg;

  localparam int WB_AW = 30;
  localparam int WB_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
`ifdef WB_ARB_WATCHDOG_EN
    , ABORT = 2'd3
`endif
  } arb_state_t;

  // Response sub-types reported by the bus master back to the UART decoder
  localparam logic [1:0] RSP_ACK     = 2'd0;
  localparam logic [1:0] RSP_ERR     = 2'd1;
  localparam logic [1:0] RSP_TIMEOUT = 2'd2;
  localparam logic [1:0] RSP_NONE    = 2'd3;

endpackage

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - Bus watchdog: counts busy cycles, flags a hung slave
// Only instantiated when WB_ARB_WATCHDOG_EN is defined.
module wb_arb_watchdog #(
  parameter int TO_W = 8
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_busy,
  input  logic i_ack,
  input  logic i_err,
  output logic o_timeout
);

  logic [TO_W-1:0] cnt;

  // The bus is idle for the cycle in which the grant moves, so clearing
  // while not busy also restarts the count on every grant change.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt <= '0;
    end else if (!i_busy || i_ack || i_err || o_timeout) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A response landing on the final cycle still wins over the timeout
  assign o_timeout = i_busy && (&cnt) && !i_ack && !i_err;

endmodule

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - Two-master round-robin Wishbone arbiter, grant held per cyc
// WB_ARB_WATCHDOG_EN enables the hung-slave watchdog and ABORT state.
module wb_arbiter_2m
  import wb_pkg::*;
#(
  parameter int AW   = WB_AW,
  parameter int DW   = WB_DW,
  parameter int TO_W = 8
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_stall,
  output logic            o_a_ack,
  output logic            o_a_err,
  output logic [DW-1:0]   o_a_data,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_stall,
  output logic            o_b_ack,
  output logic            o_b_err,
  output logic [DW-1:0]   o_b_data,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data,
  output logic [1:0]      o_owner
);

  arb_state_t state;
  logic       last_b;
  logic       gnt_a;
  logic       gnt_b;
  logic       owner_cyc;
  logic       timeout;

  assign gnt_a     = (state == GNT_A);
  assign gnt_b     = (state == GNT_B);
  assign owner_cyc = (gnt_a & i_a_cyc) | (gnt_b & i_b_cyc);

`ifdef WB_ARB_WATCHDOG_EN
  wb_arb_watchdog #(
    .TO_W(TO_W)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_busy   (owner_cyc),
    .i_ack    (i_wb_ack),
    .i_err    (i_wb_err),
    .o_timeout(timeout)
  );
`else
  logic unused_to_w;
  assign unused_to_w = (TO_W > 0);
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      last_b  <= 1'b1;
      o_owner <= 2'b00;
    end else begin
`ifdef WB_ARB_WATCHDOG_EN
      if (timeout) begin
        state   <= ABORT;
        o_owner <= 2'b00;
      end else
`endif
      case (state)
        IDLE: begin
          // On a tie the master that was not served last wins
          if (i_a_cyc && (!i_b_cyc || last_b)) begin
            state <= GNT_A; last_b <= 1'b0; o_owner <= 2'b01;
          end else if (i_b_cyc) begin
            state <= GNT_B; last_b <= 1'b1; o_owner <= 2'b10;
          end
        end
        GNT_A: begin
          if (!i_a_cyc) begin
            if (i_b_cyc) begin
              state <= GNT_B; last_b <= 1'b1; o_owner <= 2'b10;
            end else begin
              state <= IDLE; o_owner <= 2'b00;
            end
          end
        end
        GNT_B: begin
          if (!i_b_cyc) begin
            if (i_a_cyc) begin
              state <= GNT_A; last_b <= 1'b0; o_owner <= 2'b01;
            end else begin
              state <= IDLE; o_owner <= 2'b00;
            end
          end
        end
`ifdef WB_ARB_WATCHDOG_EN
        ABORT: begin
          if (!(last_b ? i_b_cyc : i_a_cyc)) begin
            state <= IDLE; o_owner <= 2'b00;
          end
        end
`endif
        default: begin
          state <= IDLE; o_owner <= 2'b00;
        end
      endcase
    end
  end

  assign o_wb_cyc  = owner_cyc & ~timeout;
  assign o_wb_stb  = ((gnt_a & i_a_stb) | (gnt_b & i_b_stb)) & ~timeout;
  assign o_wb_we   = (gnt_a & i_a_we) | (gnt_b & i_b_we);
  assign o_wb_addr = gnt_a ? i_a_addr : (gnt_b ? i_b_addr : '0);
  assign o_wb_data = gnt_a ? i_a_data : (gnt_b ? i_b_data : '0);
  assign o_wb_sel  = gnt_a ? i_a_sel  : (gnt_b ? i_b_sel  : '0);

  assign o_a_stall = gnt_a ? i_wb_stall : 1'b1;
  assign o_a_ack   = gnt_a & i_wb_ack;
  assign o_a_err   = gnt_a & (i_wb_err | timeout);
  assign o_a_data  = i_wb_data;

  assign o_b_stall = gnt_b ? i_wb_stall : 1'b1;
  assign o_b_ack   = gnt_b & i_wb_ack;
  assign o_b_err   = gnt_b & (i_wb_err | timeout);
  assign o_b_data  = i_wb_data;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb/tb_wb_arbiter_2m.sv - Directed self-checking bench for wb_arbiter_2m
// Define WB_ARB_WATCHDOG_EN to add the watchdog scenario (TO_W=4).
module tb_wb_arbiter_2m;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
  logic [AW-1:0] a_addr, b_addr, wb_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, wb_wdata, wb_rdata;
  logic [3:0]    a_sel, b_sel, wb_sel;
  logic          a_stall, a_ack, a_err, b_stall, b_ack, b_err;
  logic          wb_cyc, wb_stb, wb_we, wb_stall, wb_ack, wb_err;
  logic [1:0]    owner;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(
    .AW(AW), .DW(DW), .TO_W(4)
  ) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
    .i_a_data(a_wdata), .i_a_sel(a_sel),
    .o_a_stall(a_stall), .o_a_ack(a_ack), .o_a_err(a_err), .o_a_data(a_rdata),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
    .i_b_data(b_wdata), .i_b_sel(b_sel),
    .o_b_stall(b_stall), .o_b_ack(b_ack), .o_b_err(b_err), .o_b_data(b_rdata),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_wdata), .o_wb_sel(wb_sel),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_rdata),
    .o_owner(owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_cyc = 0; a_stb = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_sel = '0;
    b_cyc = 0; b_stb = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_sel = '0;
    wb_stall = 0; wb_ack = 0; wb_err = 0; wb_rdata = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    #2;
    n_checks++; if (owner !== 2'b00) begin n_fail++; $display("FAIL reset_owner: got %b want 00", owner); end
    n_checks++; if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin n_fail++; $display("FAIL reset_bus_ctl: got %b want 000", {wb_cyc, wb_stb, wb_we}); end
    n_checks++; if ({wb_addr, wb_wdata, wb_sel} !== '0) begin n_fail++; $display("FAIL reset_bus_data: got %h/%h/%h want 0", wb_addr, wb_wdata, wb_sel); end
    n_checks++; if ({a_stall, b_stall, a_ack, b_ack, a_err, b_err} !== 6'b110000) begin n_fail++; $display("FAIL reset_resp: got %b want 110000", {a_stall, b_stall, a_ack, b_ack, a_err, b_err}); end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    tick(); a_cyc = 1; a_stb = 1; a_we = 0; a_addr = 30'h10; #1;
    n_checks++; if ({owner, wb_cyc} !== 3'b000) begin n_fail++; $display("FAIL grant_latency: got owner=%b cyc=%b want 00/0", owner, wb_cyc); end
    tick(); #1;
    n_checks++; if (owner !== 2'b01) begin n_fail++; $display("FAIL read_owner: got %b want 01", owner); end
    n_checks++; if ({wb_cyc, wb_stb, wb_we, wb_addr} !== {3'b110, 30'h10}) begin n_fail++; $display("FAIL read_bus: got %b%b%b addr=%h want 110 addr=10", wb_cyc, wb_stb, wb_we, wb_addr); end
    n_checks++; if ({a_stall, b_stall} !== 2'b01) begin n_fail++; $display("FAIL read_stall: got %b want 01", {a_stall, b_stall}); end
    tick(); a_stb = 0;
    tick(); wb_ack = 1; wb_rdata = 32'hDEADBEEF; a_cyc = 0; #1;
    n_checks++; if ({a_ack, b_ack, b_stall} !== 3'b101) begin n_fail++; $display("FAIL read_ack: got %b want 101", {a_ack, b_ack, b_stall}); end
    n_checks++; if (a_rdata !== 32'hDEADBEEF || b_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data: got %h/%h want deadbeef", a_rdata, b_rdata); end
    n_checks++; if (wb_cyc !== 1'b0) begin n_fail++; $display("FAIL read_drop_cyc: got %b want 0", wb_cyc); end
    tick(); wb_ack = 0; #1;
    n_checks++; if (owner !== 2'b00) begin n_fail++; $display("FAIL read_release: got %b want 00", owner); end
    wb_ack = 1; wb_err = 1; #1;
    n_checks++; if ({a_ack, b_ack, a_err, b_err} !== 4'b0000) begin n_fail++; $display("FAIL stray_resp: got %b want 0000", {a_ack, b_ack, a_err, b_err}); end
    wb_ack = 0; wb_err = 0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_own [3] = '{2'b01, 2'b10, 2'b01};
    reset_n = 0; tick(); reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); a_cyc = 1; a_stb = 1; b_cyc = 1; b_stb = 1;
      tick(); #1;
      n_checks++; if (owner !== exp_own[i]) begin n_fail++; $display("FAIL rr_grant_%0d: got %b want %b", i, owner, exp_own[i]); end
      tick(); wb_ack = 1; a_cyc = 0; a_stb = 0; b_cyc = 0; b_stb = 0; #1;
      n_checks++; if ({b_ack, a_ack} !== exp_own[i]) begin n_fail++; $display("FAIL rr_ack_%0d: got %b want %b", i, {b_ack, a_ack}, exp_own[i]); end
      tick(); wb_ack = 0;
    end
  endtask

  task automatic test_burst_handover();
    tick(); a_cyc = 1; a_stb = 1; a_we = 1; a_sel = 4'hF;
    tick(); b_cyc = 1; b_stb = 1; b_addr = 30'h40; #1;
    n_checks++; if (owner !== 2'b01) begin n_fail++; $display("FAIL burst_owner: got %b want 01", owner); end
    for (int k = 0; k < 4; k++) begin
      a_addr = 30'h20 + k; a_wdata = 32'h1000 + k; wb_ack = 1; #1;
      n_checks++; if (wb_wdata !== 32'h1000 + k || wb_we !== 1'b1 || wb_addr !== 30'h20 + k) begin n_fail++; $display("FAIL burst_wr_%0d: got we=%b addr=%h data=%h", k, wb_we, wb_addr, wb_wdata); end
      n_checks++; if ({a_ack, b_ack, b_stall} !== 3'b101) begin n_fail++; $display("FAIL burst_b_held_%0d: got %b want 101", k, {a_ack, b_ack, b_stall}); end
      tick();
    end
    a_cyc = 0; a_stb = 0; a_we = 0; wb_ack = 0; #1;
    n_checks++; if ({wb_cyc, b_stall} !== 2'b01) begin n_fail++; $display("FAIL handover_gap: got %b want 01", {wb_cyc, b_stall}); end
    tick(); #1;
    n_checks++; if (owner !== 2'b10) begin n_fail++; $display("FAIL handover_owner: got %b want 10", owner); end
    n_checks++; if ({wb_cyc, wb_addr, b_stall, a_stall} !== {1'b1, 30'h40, 2'b01}) begin n_fail++; $display("FAIL handover_bus: got cyc=%b addr=%h stall=%b%b", wb_cyc, wb_addr, b_stall, a_stall); end
  endtask

  task automatic test_err();
    tick(); b_stb = 0; wb_err = 1; #1;
    n_checks++; if ({b_err, a_err, b_ack} !== 3'b100) begin n_fail++; $display("FAIL err_route: got %b want 100", {b_err, a_err, b_ack}); end
    tick(); wb_err = 0; #1;
    n_checks++; if (owner !== 2'b10) begin n_fail++; $display("FAIL err_hold: got %b want 10", owner); end
    b_cyc = 0; #1;
    tick(); #1;
    n_checks++; if (owner !== 2'b00) begin n_fail++; $display("FAIL err_release: got %b want 00", owner); end
  endtask

  task automatic test_reset_mid_burst();
    tick(); b_cyc = 1; b_stb = 1; b_we = 1; b_addr = 30'h55; b_wdata = 32'hCAFE; b_sel = 4'h3;
    tick(); #1;
    n_checks++; if ({owner, wb_cyc, wb_sel} !== {2'b10, 1'b1, 4'h3}) begin n_fail++; $display("FAIL rst_pre: got owner=%b cyc=%b sel=%h", owner, wb_cyc, wb_sel); end
    #1 reset_n = 0; #1;
    n_checks++; if ({owner, wb_cyc, wb_stb, wb_we} !== 5'b00000) begin n_fail++; $display("FAIL rst_async_ctl: got %b want 00000", {owner, wb_cyc, wb_stb, wb_we}); end
    n_checks++; if ({wb_addr, wb_wdata, wb_sel} !== '0 || {a_stall, b_stall, b_ack, b_err} !== 4'b1100) begin n_fail++; $display("FAIL rst_async_data: addr=%h data=%h sel=%h resp=%b", wb_addr, wb_wdata, wb_sel, {a_stall, b_stall, b_ack, b_err}); end
    idle_inputs();
    tick(); reset_n = 1;
  endtask

`ifdef WB_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int early = 0;
    tick(); a_cyc = 1; a_stb = 1; a_addr = 30'h77;
    tick(); b_cyc = 1; b_stb = 1; #1;
    n_checks++; if ({owner, wb_cyc} !== 3'b011) begin n_fail++; $display("FAIL wd_grant: got %b want 011", {owner, wb_cyc}); end
    a_stb = 0;
    for (int k = 0; k < 15; k++) begin
      #1 if (a_err !== 1'b0 || wb_cyc !== 1'b1) early++;
      tick();
    end
    n_checks++; if (early !== 0) begin n_fail++; $display("FAIL wd_early: got %0d bad cycles want 0", early); end
    #1;
    n_checks++; if ({a_err, b_err, wb_cyc, wb_stb} !== 4'b1000) begin n_fail++; $display("FAIL wd_pulse: got %b want 1000", {a_err, b_err, wb_cyc, wb_stb}); end
    tick(); #1;
    n_checks++; if ({a_err, a_stall, b_stall, wb_cyc, owner} !== 6'b011000) begin n_fail++; $display("FAIL wd_abort: got %b want 011000", {a_err, a_stall, b_stall, wb_cyc, owner}); end
    a_cyc = 0;
    tick(); #1;
    n_checks++; if (owner !== 2'b00) begin n_fail++; $display("FAIL wd_idle: got %b want 00", owner); end
    tick(); #1;
    n_checks++; if ({owner, wb_cyc} !== 3'b101) begin n_fail++; $display("FAIL wd_b_grant: got %b want 101", {owner, wb_cyc}); end
    idle_inputs();
    tick(); tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_handover();
    test_err();
    test_reset_mid_burst();
`ifdef WB_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
